bram_req_arbiter: RTL
=====================

Name: bram_req_arbiter

Overview:
- Upstream of dual_ported_bram. Collects read/write requests from `processing_engines` engines and issues up to two per cycle, one on BRAM port A and one on port B.
- Round-robin fairness across engines.
- Tags each issued read with its engine id and routes the returned data back to that engine one cycle later.
- Single clock domain; BRAM clka and clkb are both driven from clk.

Parameters:
- value_width, 32, data word width
- index_width, 8, BRAM address width (depth 2**index_width)
- processing_engines, 4, number of requesting engines N (2..16)

Ports:
- clk  in  1  clock; also drives BRAM clka/clkb
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N  per-engine request valid
- req_ready  out  N  per-engine grant (handshake fires when valid && ready)
- req_we  in  N  per-engine 1=write, 0=read
- req_addr  in  N*index_width  per-engine address, engine i at slice [i*IW +: IW]
- req_wdata  in  N*value_width  per-engine write data
- rsp_valid  out  N  per-engine read data valid
- rsp_rdata  out  N*value_width  per-engine read data
- ena, enb  out  1  BRAM port enables
- wea, web  out  1  BRAM write enables
- addra, addrb  out  index_width  BRAM addresses
- dia, dib  out  value_width  BRAM write data
- doa, dob  in  value_width  BRAM registered read data

Behaviour:
- Reset: asynchronous, active-low.
  - rr_ptr=0.
  - Tag pipeline valids (va, vb) = 0; tags ida, idb = 0.
  - rsp_valid=0, rsp_rdata=0.
- Grant selection is combinational each cycle, scanning engines from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1).
  - First valid engine found → grant g0, routed to port A.
  - Next valid engine found → candidate g1, routed to port B.
- Conflict rule: if g1's address equals g0's address and either request is a write, g1 is not granted this cycle. No further candidate is searched; port B stays idle.
  - Two reads to the same address are allowed.
- req_ready[i]=1 only for the granted engine(s). It is never asserted while rst_n=0.
- Port driving:
  - Port A: ena=1 iff g0 exists; wea=req_we[g0]; addra/dia taken from g0.
  - Port B: same, from g1.
  - Idle port: en=0, we=0, addr=0, data=0.
- rr_ptr update on any grant: set to (last granted index + 1) mod N. Unchanged when nothing is granted.
- Read tagging, registered:
  - va <= grant on A && !wea; ida <= g0.
  - vb and idb likewise for port B.
  - Writes produce no response.
- Response, one cycle after the handshake (matches BRAM registered read):
  - rsp_valid[i] = (va && ida==i) || (vb && idb==i). Registered path; no combinational path from req_* inputs.
  - rsp_rdata slice i = doa if (va && ida==i), else dob if (vb && idb==i), else 0.
  - One engine can receive at most one response per cycle.
- Single-outstanding rule: an engine with a read in flight (va/vb tag equal to its id) is not granted a new request that cycle. This prevents a double response in one cycle.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid is produced. BRAM contents are unaffected.
- Throughput: 2 requests/cycle sustained when addresses do not conflict.

Decomposition:
- Shared package (bram_pkg) holds:
  - Defaults for value_width, index_width, processing_engines.
  - localparam ID_W = $clog2(processing_engines).
  - Port-select encodings PORT_A=0, PORT_B=1.
- One sub-module, rr_pick2: combinational two-winner round-robin finder.
  - Inputs: request mask, rr_ptr.
  - Outputs: g0/g1 valid flags and indices.
  - Instantiated once; conflict and outstanding masking is done in the top level.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 → req_ready=0, ena=enb=0, rsp_valid=0. Release → first grants go to engines 0 (A) and 1 (B).
- Write then read:
  - Engine 2 writes addr 0x10 data 0xDEADBEEF, alone → wea=1, addra=0x10.
  - Engine 2 then reads 0x10 → next cycle rsp_valid[2]=1, rsp_rdata[2]=0xDEADBEEF.
- Fairness: all 4 engines issue continuous reads to distinct addresses → grant pairs (0,1), (2,3), (0,1), … with each engine held off by its own outstanding read. Every engine is served within 2 cycles.
- Address conflict:
  - Engine 0 writes 0x20 while engine 1 reads 0x20 → only engine 0 granted, enb=0. Engine 1 is granted the next cycle and reads the new value.
  - Two reads to 0x20 → both granted.
- Dual response: engines 1 and 3 read 0x05=0x11 and 0x06=0x22 in the same cycle → next cycle rsp_valid=4'b1010, rsp_rdata[1]=0x11, rsp_rdata[3]=0x22.
- Reset mid-flight: grant reads to engines 0 and 1, then assert rst_n=0 before the next edge → rsp_valid stays 0 and rr_ptr=0 after release.

Source files
------------

// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the BRAM request arbiter slice.
//   - Default widths and engine count used as parameter defaults.
//   - ID_W: engine-id width for the default engine count.
//   - port_sel_e: names the two BRAM ports so per-port vectors read clearly.
//   - rr_next(): round-robin successor of an engine index.
// -----------------------------------------------------------------------------
package bram_pkg;

    localparam int VALUE_WIDTH        = 32;
    localparam int INDEX_WIDTH        = 8;
    localparam int PROCESSING_ENGINES = 4;
    localparam int ID_W               = $clog2(PROCESSING_ENGINES);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    // Index that follows idx in a ring of n engines.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-winner round-robin finder. Scans the request mask starting
// at rr_ptr with wrap-around; the first set bit is winner g0, the next one is
// winner g1.
// Ports:
//   mask      in   n     eligible requesters
//   rr_ptr    in   id_w  engine index where the scan starts
//   g0_valid  out  1     first winner found
//   g0_idx    out  id_w  first winner index (0 when none)
//   g1_valid  out  1     second winner found
//   g1_idx    out  id_w  second winner index (0 when none)
// -----------------------------------------------------------------------------
module rr_pick2 #(
    parameter int n    = 4,
    parameter int id_w = $clog2(n)
) (
    input  logic [n-1:0]    mask,
    input  logic [id_w-1:0] rr_ptr,
    output logic            g0_valid,
    output logic [id_w-1:0] g0_idx,
    output logic            g1_valid,
    output logic [id_w-1:0] g1_idx
);

    logic [id_w-1:0] idx;

    always_comb begin
        // NOTE: every output gets a value before the loop so no path through
        // the scan leaves one unassigned and infers a latch.
        g0_valid = 1'b0;
        g0_idx   = '0;
        g1_valid = 1'b0;
        g1_idx   = '0;
        idx      = '0;
        for (int k = 0; k < n; k++) begin
            idx = id_w'((int'(rr_ptr) + k) % n);
            if (mask[idx]) begin
                if (!g0_valid) begin
                    g0_valid = 1'b1;
                    g0_idx   = idx;
                end else if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_idx   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/bram_req_arbiter.sv
// -----------------------------------------------------------------------------
// bram_req_arbiter
// Arbitrates read/write requests from N engines onto the two ports of a
// dual-ported BRAM (clka/clkb driven from clk), up to one request per port per
// cycle, with round-robin fairness. Reads are tagged with the engine id and the
// BRAM's registered read data is routed back to that engine one cycle later.
// Ports:
//   clk, rst_n            clock (also BRAM clka/clkb), async active-low reset
//   req_valid/ready/we    per-engine handshake and write flag
//   req_addr, req_wdata   per-engine address / write data, engine i at slice i
//   rsp_valid, rsp_rdata  per-engine read response, one cycle after handshake
//   ena/wea/addra/dia     BRAM port A controls
//   enb/web/addrb/dib     BRAM port B controls
//   doa, dob              BRAM registered read data
// -----------------------------------------------------------------------------
module bram_req_arbiter
    import bram_pkg::*;
#(
    parameter int value_width        = VALUE_WIDTH,
    parameter int index_width        = INDEX_WIDTH,
    parameter int processing_engines = PROCESSING_ENGINES
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [processing_engines-1:0]           req_valid,
    output logic [processing_engines-1:0]           req_ready,
    input  logic [processing_engines-1:0]           req_we,
    input  logic [processing_engines*index_width-1:0] req_addr,
    input  logic [processing_engines*value_width-1:0] req_wdata,
    output logic [processing_engines-1:0]           rsp_valid,
    output logic [processing_engines*value_width-1:0] rsp_rdata,
    output logic                                    ena,
    output logic                                    enb,
    output logic                                    wea,
    output logic                                    web,
    output logic [index_width-1:0]                  addra,
    output logic [index_width-1:0]                  addrb,
    output logic [value_width-1:0]                  dia,
    output logic [value_width-1:0]                  dib,
    input  logic [value_width-1:0]                  doa,
    input  logic [value_width-1:0]                  dob
);

    localparam int id_w = $clog2(processing_engines);
    typedef logic [id_w-1:0] id_t;

    logic [index_width-1:0] addr_arr  [processing_engines];
    logic [value_width-1:0] wdata_arr [processing_engines];

    id_t                          rr_ptr;
    logic [1:0]                   tag_v;       // read in flight, per port
    id_t                          tag_id [2];  // owning engine, per port
    logic [processing_engines-1:0] busy;
    logic [processing_engines-1:0] mask;

    logic g0_valid, g1_valid;
    id_t  g0_idx, g1_idx;
    logic conflict;
    logic [1:0] port_grant;

    // Unpack per-engine slices and find engines that already have a read in
    // flight; those sit out this cycle so they never get two responses at once.
    always_comb begin
        busy = '0;
        for (int i = 0; i < processing_engines; i++) begin
            addr_arr[i]  = req_addr[i*index_width +: index_width];
            wdata_arr[i] = req_wdata[i*value_width +: value_width];
            busy[i] = (tag_v[PORT_A] && tag_id[PORT_A] == id_t'(i)) ||
                      (tag_v[PORT_B] && tag_id[PORT_B] == id_t'(i));
        end
    end

    // Gating with rst_n keeps req_ready low for the whole reset window.
    assign mask = req_valid & ~busy & {processing_engines{rst_n}};

    rr_pick2 #(
        .n    (processing_engines),
        .id_w (id_w)
    ) u_pick (
        .mask     (mask),
        .rr_ptr   (rr_ptr),
        .g0_valid (g0_valid),
        .g0_idx   (g0_idx),
        .g1_valid (g1_valid),
        .g1_idx   (g1_idx)
    );

    // Same address with a write on either side would make port B's result
    // depend on BRAM collision behaviour, so g1 simply waits a cycle.
    // Two reads of one address are harmless and both proceed.
    always_comb begin
        conflict = g1_valid &&
                   (addr_arr[g1_idx] == addr_arr[g0_idx]) &&
                   (req_we[g0_idx] || req_we[g1_idx]);
        port_grant         = '0;
        port_grant[PORT_A] = g0_valid;
        port_grant[PORT_B] = g1_valid && !conflict;
    end

    always_comb begin
        req_ready = '0;
        if (port_grant[PORT_A]) req_ready[g0_idx] = 1'b1;
        if (port_grant[PORT_B]) req_ready[g1_idx] = 1'b1;
    end

    // Idle ports drive all-zero controls.
    always_comb begin
        ena   = port_grant[PORT_A];
        wea   = port_grant[PORT_A] & req_we[g0_idx];
        addra = port_grant[PORT_A] ? addr_arr[g0_idx]  : '0;
        dia   = port_grant[PORT_A] ? wdata_arr[g0_idx] : '0;
        enb   = port_grant[PORT_B];
        web   = port_grant[PORT_B] & req_we[g1_idx];
        addrb = port_grant[PORT_B] ? addr_arr[g1_idx]  : '0;
        dib   = port_grant[PORT_B] ? wdata_arr[g1_idx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            rr_ptr         <= '0;
            tag_v          <= '0;
            tag_id[PORT_A] <= '0;
            tag_id[PORT_B] <= '0;
        end else begin
            tag_v[PORT_A]  <= ena && !wea;
            tag_v[PORT_B]  <= enb && !web;
            tag_id[PORT_A] <= g0_idx;
            tag_id[PORT_B] <= g1_idx;
            // Resume the scan just past the last engine served this cycle.
            if (port_grant[PORT_B])
                rr_ptr <= id_t'(rr_next(int'(g1_idx), processing_engines));
            else if (port_grant[PORT_A])
                rr_ptr <= id_t'(rr_next(int'(g0_idx), processing_engines));
        end
    end

    // Responses decode the tag registers only; port A wins if both match,
    // which the busy mask already prevents.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < processing_engines; i++) begin
            if (tag_v[PORT_A] && tag_id[PORT_A] == id_t'(i)) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*value_width +: value_width] = doa;
            end else if (tag_v[PORT_B] && tag_id[PORT_B] == id_t'(i)) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*value_width +: value_width] = dob;
            end
        end
    end

endmodule
